irq_timer_gen: RTL and testbench

IRQ_TIMER_GEN -- requirements
Module: irq_timer_gen

---
 rtl/irq_timer_gen.sv | 118 +++++++++++
 tb/tb_irq_timer_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/irq_timer_gen.sv
// Periodic interrupt generator: NUM_CH independent counters, each raising either a
// one-cycle pulse or a level held until end-of-interrupt on irq bit BASE_IRQ+channel.
module irq_timer_gen #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int IRQ_W    = 32,
    parameter int BASE_IRQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    input  logic [IRQ_W-1:0]  eoi,
    output logic [IRQ_W-1:0]  irq,
    output logic [NUM_CH-1:0] overrun
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : gen_bad_num_ch
        $error("irq_timer_gen: NUM_CH must be 1..16");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : gen_bad_cnt_w
        $error("irq_timer_gen: CNT_W must be 2..32");
    end
    if (BASE_IRQ < 0 || BASE_IRQ + NUM_CH > IRQ_W) begin : gen_bad_irq_map
        $error("irq_timer_gen: BASE_IRQ+NUM_CH exceeds IRQ_W");
    end

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] fire, pulse, ack;
    logic [IRQ_W-1:0]  irq_q, irq_d;

    // Only bits BASE_IRQ..BASE_IRQ+NUM_CH-1 of eoi matter; the rest are dropped.
    logic unused_eoi;
    assign unused_eoi = ^eoi;

    always_comb begin
        irq_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            mode_d[i]   = mode_q[i];
            en_d[i]     = en_q[i];
            pend_d[i]   = pend_q[i];
            ovr_d[i]    = ovr_q[i];
            ack[i]      = eoi[BASE_IRQ + i];
            fire[i]     = en_q[i] && (cnt_q[i] == period_q[i]);

            if (!en_q[i] || fire[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end

            pulse[i] = fire[i] && !mode_q[i];

            // Level mode: a fire coinciding with eoi is a fresh event, not an overrun.
            if (mode_q[i]) begin
                if (fire[i]) begin
                    pend_d[i] = 1'b1;
                    if (pend_q[i] && !ack[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                end else if (ack[i]) begin
                    pend_d[i] = 1'b0;
                end
            end

            if (cfg_we && (cfg_ch == 4'(i))) begin
                period_d[i] = cfg_period;
                mode_d[i]   = cfg_mode;
                en_d[i]     = cfg_en;
                cnt_d[i]    = '0;
                pend_d[i]   = 1'b0;
                ovr_d[i]    = 1'b0;
                pulse[i]    = 1'b0;
            end

            irq_d[BASE_IRQ + i] = mode_d[i] ? pend_d[i] : pulse[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '1;
                cnt_q[i]    <= '0;
            end
            mode_q <= '0;
            en_q   <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
            irq_q  <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_irq_timer_gen.sv
// Directed bench for irq_timer_gen: each step queues the expected irq/overrun for the
// next edge, then pops and compares it one time unit after that edge.
module tb_irq_timer_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_mode;
    logic        cfg_en;
    logic [31:0] eoi;
    logic [31:0] irq;
    logic [1:0]  overrun;

    irq_timer_gen dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_en     (cfg_en),
        .eoi        (eoi),
        .irq        (irq),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] irq;
        logic [1:0]  ovr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] B4 = 32'h0000_0010;
    localparam logic [31:0] B5 = 32'h0000_0020;
    localparam logic [31:0] Z  = 32'h0;

    task automatic step(input string tag, input logic [31:0] ei, input logic [1:0] eo);
        exp_t e;
        sb.push_back('{tag, ei, eo});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, got irq=%h ovr=%b", tag, irq, overrun);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert ({irq, overrun} === {e.irq, e.ovr}) else begin
                n_fail++;
                $error("FAIL %s: got irq=%h ovr=%b, expected irq=%h ovr=%b",
                       e.tag, irq, overrun, e.irq, e.ovr);
            end
        end
    endtask

    task automatic wr(input logic [3:0] ch, input logic [15:0] p, input logic m,
                      input logic en, input string tag, input logic [31:0] ei,
                      input logic [1:0] eo);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_mode   = m;
        cfg_en     = en;
        step(tag, ei, eo);
        cfg_we     = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_mode   = 1'b0;
        cfg_en     = 1'b0;
        eoi        = '0;

        step("reset0", Z, 2'b00);
        step("reset1", Z, 2'b00);
        reset = 1'b0;
        for (int k = 0; k < 1000; k++) step("idle", Z, 2'b00);

        // ch0 pulse, P=3: pulses on edges 4, 8, 12 after the write
        wr(4'd0, 16'd3, 1'b0, 1'b1, "wr_p3", Z, 2'b00);
        for (int k = 1; k <= 15; k++) step("pulse_p3", (k % 4 == 0) ? B4 : Z, 2'b00);
        // rewrite on the edge where a fire was due: no pulse on the write edge
        wr(4'd0, 16'd5, 1'b0, 1'b1, "wr_p5_nofire", Z, 2'b00);
        for (int k = 1; k <= 12; k++) begin
            if (k == 8) begin
                wr(4'd15, 16'd1, 1'b1, 1'b0, "wr_ch15_ignored", Z, 2'b00);
            end else begin
                step("pulse_p5", (k % 6 == 0) ? B4 : Z, 2'b00);
            end
        end

        // P=0 pulse mode: continuous high
        wr(4'd0, 16'd0, 1'b0, 1'b1, "wr_p0", Z, 2'b00);
        for (int k = 1; k <= 5; k++) step("pulse_p0", B4, 2'b00);
        wr(4'd0, 16'd0, 1'b0, 1'b0, "wr_ch0_off", Z, 2'b00);
        for (int k = 1; k <= 3; k++) step("ch0_off", Z, 2'b00);

        // ch1 level, P=7: set at 8, overrun at 16, eoi clears irq but not overrun
        wr(4'd1, 16'd7, 1'b1, 1'b1, "wr_lvl_p7", Z, 2'b00);
        for (int k = 1; k <= 7; k++)  step("lvl_wait", Z, 2'b00);
        for (int k = 8; k <= 15; k++) step("lvl_held", B5, 2'b00);
        step("lvl_ovr", B5, 2'b10);
        eoi = B5;
        step("lvl_eoi", Z, 2'b10);
        eoi = Z;
        for (int k = 18; k <= 23; k++) step("lvl_cleared", Z, 2'b10);
        step("lvl_refire", B5, 2'b10);
        wr(4'd1, 16'd7, 1'b1, 1'b0, "wr_ch1_clr", Z, 2'b00);

        // ch0 level, P=4: eoi on the fire edge keeps irq, no overrun
        wr(4'd0, 16'd4, 1'b1, 1'b1, "wr_lvl_p4", Z, 2'b00);
        for (int k = 1; k <= 4; k++) step("lvl4_wait", Z, 2'b00);
        for (int k = 5; k <= 9; k++) step("lvl4_held", B4, 2'b00);
        eoi = B4 | 32'h1;
        step("lvl4_eoi_on_fire", B4, 2'b00);
        eoi = Z;
        for (int k = 11; k <= 14; k++) step("lvl4_pend", B4, 2'b00);
        step("lvl4_ovr", B4, 2'b01);

        // reset while ch1 pending/overrun and ch0 counting
        wr(4'd0, 16'd9, 1'b0, 1'b1, "wr_ch0_p9", Z, 2'b00);
        wr(4'd1, 16'd2, 1'b1, 1'b1, "wr_ch1_p2", Z, 2'b00);
        step("rst_seq_a", Z, 2'b00);
        step("rst_seq_b", Z, 2'b00);
        step("rst_seq_fire", B5, 2'b00);
        step("rst_seq_hold", B5, 2'b00);
        step("rst_seq_hold", B5, 2'b00);
        step("rst_seq_ovr", B5, 2'b10);
        reset      = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 4'd0;
        cfg_period = 16'd0;
        cfg_mode   = 1'b0;
        cfg_en     = 1'b1;
        eoi        = '1;
        step("rst_priority", Z, 2'b00);
        reset  = 1'b0;
        cfg_we = 1'b0;
        eoi    = Z;
        for (int k = 0; k < 20; k++) step("post_reset_inert", Z, 2'b00);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
